iter_mul: RTL

ITER_MUL -- requirements
Module: iter_mul

---
 rtl/iter_mul.sv | 107 ++++++++++
 1 files changed

// File: rtl/iter_mul.sv
// rtl/iter_mul.sv - iterative radix-2 shift-add multiplier, signed or unsigned, WIDTH+1 cycle latency
//
// Ports:
//    clk        rising-edge clock
//    rst        asynchronous active-high reset
//    start      begin a multiply (accepted only while idle)
//    sign_flag  1 = two's-complement operands, 0 = unsigned; captured with start
//    A, B       multiplicand / multiplier; captured with start
//    HI, LO     upper / lower halves of the 2*WIDTH-bit product, updated only on completion
//    busy       high while an operation is in flight
//    done       one-cycle pulse when HI/LO carry a new result
module iter_mul #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sign_flag,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             busy,
   output logic             done
);

   localparam int            CW        = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] acc;
   logic               neg;

   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     add_sum;
   logic [2*WIDTH-1:0] acc_step;
   logic [2*WIDTH-1:0] result;

   // Operands are multiplied as unsigned magnitudes and the sign is applied
   // once at the end. The most-negative value negates to itself, which read
   // as unsigned is exactly 2^(WIDTH-1), so no extra bit is needed.
   always_comb begin
      a_mag = (sign_flag && A[WIDTH-1]) ? -A : A;
      b_mag = (sign_flag && B[WIDTH-1]) ? -B : B;
   end

   // acc = {partial product high half, remaining multiplier bits}. The add
   // is one bit wider than the high half so its carry survives the shift.
   always_comb begin
      add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : '0)};
      acc_step = {add_sum, acc[WIDTH-1:1]};
      result   = neg ? -acc : acc;
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         mcand <= '0;
         acc   <= '0;
         neg   <= 1'b0;
         HI    <= '0;
         LO    <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mcand <= a_mag;
                  acc   <= {{WIDTH{1'b0}}, b_mag};
                  neg   <= sign_flag & (A[WIDTH-1] ^ B[WIDTH-1]);
                  cnt   <= '0;
                  state <= CALC;
               end
            end
            CALC: begin
               acc <= acc_step;
               cnt <= cnt + CW'(1);
               if (cnt == LAST_STEP) begin
                  state <= FIN;
               end
            end
            FIN: begin
               {HI, LO} <= result;
               done     <= 1'b1;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
